// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war game controller: round result codes,
// controller states and the rope centre index.
package tug_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } winner_t;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    function automatic int centre_idx(input int n_lights);
        return (n_lights - 1) / 2;
    endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player score register: increments on a one-cycle inc pulse and
// saturates at all-ones instead of wrapping.
module score_counter #(
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [SCORE_W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + SCORE_W'(1);
        end
    end

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller: moves a one-hot rope light toward the pulling
// player, awards points off either edge, holds the result, then re-centres.
module tug_of_war_ctrl
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = 9,
    parameter int HOLD_CYCLES = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l_press,
    input  logic                r_press,
    output logic [N_LIGHTS-1:0] lights,
    output logic [1:0]          winner,
    output logic                point,
    output logic [SCORE_W-1:0]  l_score,
    output logic [SCORE_W-1:0]  r_score,
    output logic                match_over
);

    localparam int C      = centre_idx(N_LIGHTS);
    localparam int POS_W  = $clog2(N_LIGHTS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_LEFT   = POS_W'(N_LIGHTS - 1);
    localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'(C);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

    state_t                state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    winner_t               winner_q, winner_d;
    logic [N_LIGHTS-1:0]   lights_q, lights_d;
    logic                  point_q, point_d;
    logic                  match_q, match_d;

    logic                  pull_l, pull_r, win_l, win_r, match_won;
    logic [SCORE_W-1:0]    l_after, r_after;

    // Simultaneous presses cancel; presses only count while the round is live.
    assign pull_l = (state_q == PLAY) && l_press && !r_press;
    assign pull_r = (state_q == PLAY) && r_press && !l_press;
    assign win_l  = pull_l && (pos_q == POS_LEFT);
    assign win_r  = pull_r && (pos_q == '0);

    assign l_after   = (l_score == SCORE_MAX) ? l_score : l_score + SCORE_W'(1);
    assign r_after   = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
    assign match_won = (win_l && (l_after == SCORE_WIN)) || (win_r && (r_after == SCORE_WIN));

    score_counter #(.SCORE_W(SCORE_W)) u_l_score (
        .clk   (clk),
        .reset (reset),
        .inc   (win_l),
        .count (l_score)
    );

    score_counter #(.SCORE_W(SCORE_W)) u_r_score (
        .clk   (clk),
        .reset (reset),
        .inc   (win_r),
        .count (r_score)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            pos_q    <= POS_CENTRE;
            hold_q   <= '0;
            winner_q <= NONE;
            lights_q <= N_LIGHTS'(1) << C;
            point_q  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hold_q   <= hold_d;
            winner_q <= winner_d;
            lights_q <= lights_d;
            point_q  <= point_d;
            match_q  <= match_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        unique case (state_q)
            PLAY: begin
                if (win_l || win_r) begin
                    state_d = match_won ? MATCH_OVER : HOLD;
                    hold_d  = HOLD_LOAD;
                end else if (pull_l) begin
                    pos_d = pos_q + POS_W'(1);
                end else if (pull_r) begin
                    pos_d = pos_q - POS_W'(1);
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = PLAY;
                    pos_d   = POS_CENTRE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            MATCH_OVER: ;
            default: state_d = PLAY;
        endcase
    end

    always_comb begin
        lights_d = (state_d == PLAY) ? (N_LIGHTS'(1) << pos_d) : '0;
        point_d  = win_l || win_r;
        match_d  = match_q || (state_d == MATCH_OVER);
        winner_d = winner_q;
        if (win_l) begin
            winner_d = LEFT;
        end else if (win_r) begin
            winner_d = RIGHT;
        end else if ((state_q == HOLD) && (hold_q == '0)) begin
            winner_d = NONE;
        end
    end

    assign lights     = lights_q;
    assign winner     = winner_q;
    assign point      = point_q;
    assign match_over = match_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Scoreboard bench for tug_of_war_ctrl: directed presses push hand-derived
// expected outputs; a negedge monitor pops and compares them.
module tb_tug_of_war_ctrl;

    localparam int N  = 9;
    localparam int H  = 4;
    localparam int C  = 4;
    localparam int SW = 3;

    typedef struct packed {
        logic [N-1:0]  lights;
        logic [1:0]    winner;
        logic          point;
        logic [SW-1:0] ls;
        logic [SW-1:0] rs;
        logic          mo;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          l_press = 1'b0;
    logic          r_press = 1'b0;
    logic [N-1:0]  lights;
    logic [1:0]    winner;
    logic          point;
    logic [SW-1:0] l_score;
    logic [SW-1:0] r_score;
    logic          match_over;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    tug_of_war_ctrl #(
        .N_LIGHTS    (N),
        .HOLD_CYCLES (H),
        .WIN_SCORE   (7),
        .SCORE_W     (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_press    (l_press),
        .r_press    (r_press),
        .lights     (lights),
        .winner     (winner),
        .point      (point),
        .l_score    (l_score),
        .r_score    (r_score),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int idx);
        logic [N-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] l, input int w, input bit pt,
                                input int ls, input int rs, input bit mo);
        vec_t v;
        v.lights = l;
        v.winner = 2'(w);
        v.point  = pt;
        v.ls     = SW'(ls);
        v.rs     = SW'(rs);
        v.mo     = mo;
        return v;
    endfunction

    task automatic check(input string nm, input vec_t act, input vec_t e);
        n_vec++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got lights=%b winner=%0d point=%0b l=%0d r=%0d mo=%0b, want lights=%b winner=%0d point=%0b l=%0d r=%0d mo=%0b",
                     nm, act.lights, act.winner, act.point, act.ls, act.rs, act.mo,
                     e.lights, e.winner, e.point, e.ls, e.rs, e.mo);
        end
    endtask

    // Monitor: the DUT presents a fresh registered result every cycle.
    initial begin
        vec_t act;
        vec_t e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {lights, winner, point, l_score, r_score, match_over};
                check(nm, act, e);
            end
        end
    end

    task automatic push(input vec_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One cycle of press inputs; expectation is the state after that edge.
    task automatic step(input bit l, input bit r, input vec_t e, input string nm);
        l_press = l;
        r_press = r;
        @(posedge clk);
        #1;
        l_press = 1'b0;
        r_press = 1'b0;
        push(e, nm);
    endtask

    // Full round from centre won by one side; pl/pr are the scores beforehand.
    task automatic round(input bit left, input int pl, input int pr, input bit last);
        int nl;
        int nr;
        int w;
        nl = left ? pl + 1 : pl;
        nr = left ? pr : pr + 1;
        w  = left ? 1 : 2;
        for (int k = 1; k <= C; k++)
            step(left, !left, mk(oh(left ? C + k : C - k), 0, 0, pl, pr, 0), "pull");
        step(left, !left, mk('0, w, 1, nl, nr, last), "round_win");
        if (!last) begin
            for (int k = 1; k < H; k++)
                step(k[0], 1'b1, mk('0, w, 0, nl, nr, 0), "hold_ignore");
            step(1'b1, 1'b0, mk(oh(C), 0, 0, nl, nr, 0), "recentre");
        end
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        push(mk(oh(C), 0, 0, 0, 0, 0), "async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(mk(oh(C), 0, 0, 0, 0, 0), "after_reset");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        push(mk(oh(C), 0, 0, 0, 0, 0), "in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, mk(oh(C), 0, 0, 0, 0, 0), "reset_values");

        step(1, 0, mk(oh(5), 0, 0, 0, 0, 0), "l1");
        step(0, 0, mk(oh(5), 0, 0, 0, 0, 0), "l1_hold");
        step(1, 0, mk(oh(6), 0, 0, 0, 0, 0), "l2");
        step(1, 0, mk(oh(7), 0, 0, 0, 0, 0), "l3");
        step(0, 1, mk(oh(6), 0, 0, 0, 0, 0), "r1");
        step(1, 1, mk(oh(6), 0, 0, 0, 0, 0), "both_cancel");
        step(0, 1, mk(oh(5), 0, 0, 0, 0, 0), "r2");
        step(0, 1, mk(oh(4), 0, 0, 0, 0, 0), "r3_centre");

        step(1, 0, mk(oh(5), 0, 0, 0, 0, 0), "five_l1");
        step(1, 0, mk(oh(6), 0, 0, 0, 0, 0), "five_l2");
        step(1, 0, mk(oh(7), 0, 0, 0, 0, 0), "five_l3");
        step(1, 0, mk(oh(8), 0, 0, 0, 0, 0), "five_l4_edge");
        step(1, 0, mk('0, 1, 1, 1, 0, 0), "five_l5_point");
        step(1, 0, mk('0, 1, 0, 1, 0, 0), "hold1");
        step(0, 1, mk('0, 1, 0, 1, 0, 0), "hold2");
        step(1, 0, mk('0, 1, 0, 1, 0, 0), "hold3");
        step(1, 1, mk(oh(4), 0, 0, 1, 0, 0), "recentred_4_after_point");
        step(1, 0, mk(oh(5), 0, 0, 1, 0, 0), "play_again");
        step(0, 1, mk(oh(4), 0, 0, 1, 0, 0), "back_centre");

        step(0, 1, mk(oh(3), 0, 0, 1, 0, 0), "rw1");
        step(0, 1, mk(oh(2), 0, 0, 1, 0, 0), "rw2");
        step(0, 1, mk(oh(1), 0, 0, 1, 0, 0), "rw3");
        step(0, 1, mk(oh(0), 0, 0, 1, 0, 0), "rw4_edge");
        step(0, 1, mk('0, 2, 1, 1, 1, 0), "rw_point");
        step(0, 1, mk('0, 2, 0, 1, 1, 0), "rw_hold1");
        reset_mid_cycle();

        round(1, 0, 0, 0);
        round(0, 1, 0, 0);
        round(1, 1, 1, 0);
        round(0, 2, 1, 0);
        round(1, 2, 2, 0);
        step(0, 0, mk(oh(C), 0, 0, 3, 2, 0), "interleaved_l3_r2");
        reset_mid_cycle();

        for (int i = 0; i < 6; i++) round(0, 0, i, 0);
        round(0, 0, 6, 1);
        step(1, 0, mk('0, 2, 0, 0, 7, 1), "over_l");
        step(0, 1, mk('0, 2, 0, 0, 7, 1), "over_r_no_wrap");
        step(1, 1, mk('0, 2, 0, 0, 7, 1), "over_both");
        step(0, 1, mk('0, 2, 0, 0, 7, 1), "over_stuck");
        reset_mid_cycle();
        step(1, 0, mk(oh(5), 0, 0, 0, 0, 0), "post_match_play");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
